imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Write-side counterpart of the instruction fetch path: receives a program as a byte stream and writes 32-bit instruction words into InstructionMemory before the PC starts fetching.
- Holds the CPU/PC stalled via cpu_hold until the full program has been written, then releases it.
- Stream format: a 4-byte little-endian word count N, then N words of 4 bytes each, little-endian.

Parameters:
- BASE_ADDR, 64'd0, byte address of the first written word (must be 4-aligned).
- MAX_WORDS, 256, largest accepted N; any larger N is a protocol error.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in valid this cycle
- byte_ready  output  1  loader accepts a byte; a transfer occurs when byte_valid && byte_ready
- mem_write_en  output  1  one-cycle write strobe to InstructionMemory
- mem_addr  output  64  byte address = BASE_ADDR + 4*index
- mem_write_data  output  32  assembled instruction word
- cpu_hold  output  1  1 = PC load disabled / CPU stalled
- done  output  1  program fully written
- error  output  1  N > MAX_WORDS (sticky)
- word_count  output  32  latched N

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; byte_ready=0, mem_write_en=0, mem_addr=BASE_ADDR, mem_write_data=0.
  - cpu_hold=1, done=0, error=0, word_count=0; byte and word indices cleared.
  - Reset asserted mid-load aborts the load immediately. Words already written remain in memory.
- States and transitions:
  - IDLE: byte_ready=0. start → LEN with byte index=0.
  - LEN: byte_ready=1. Each transfer shifts byte k into bits [8k+7:8k].
    - After the 4th transfer: N=0 → DONE; N>MAX_WORDS → ERROR; otherwise → DATA with word index=0.
    - word_count updates on the 4th transfer.
  - DATA: byte_ready=1. Bytes are assembled little-endian. The 4th transfer → WRITE.
  - WRITE (exactly 1 cycle): byte_ready=0, mem_write_en=1, mem_addr=BASE_ADDR+{index,2'b00}, mem_write_data=assembled word. Then index+1.
    - If index+1==N → DONE; else → DATA.
  - DONE: cpu_hold=0, done=1, byte_ready=0. start → LEN, clearing done and asserting cpu_hold the next cycle.
  - ERROR: error=1, cpu_hold=1, byte_ready=0. Only reset exits; start is ignored.
- cpu_hold is 0 only in DONE.
- start outside IDLE/DONE is ignored.
- A byte_valid cycle without byte_ready does not consume the byte; the source must hold byte_in.
- Stalls (byte_valid=0) are allowed at any point; partial-word state is retained indefinitely.
- Latency: mem_write_en rises on the cycle after the 4th byte of a word is accepted. Maximum throughput is one word per 5 cycles.
- Address arithmetic is 64-bit modulo 2^64. The index counter is 32-bit.
- mem_write_en is never asserted outside WRITE.

Test Plan:
- Reset, then start, then stream 02 00 00 00 | 13 05 A0 00 | 63 04 B5 00 with byte_valid held high → writes 0x00A00513 @0x0 and 0x00B50463 @0x4. done=1 and cpu_hold=0 on the cycle after the second write.
- N=0 (00 00 00 00) → DONE immediately after the 4th byte, with no mem_write_en pulse and word_count=0.
- N=257 with MAX_WORDS=256 → error=1, cpu_hold=1, byte_ready=0. A subsequent start is ignored, and only reset_n=0 clears error.
- Random byte_valid gaps in a 3-word load, plus byte_valid=1 during the WRITE cycle → data is identical to the gap-free run, and the byte held during WRITE is accepted on the next cycle.
- reset_n=0 after the 2nd byte of word 1 (BASE_ADDR=64'h1000) → all outputs return to reset values. A fresh load then writes its first word at 0x1000.
- From DONE, start and load 1 word 0xDEADBEEF → cpu_hold=1 during the load, with a write to BASE_ADDR+0 followed by DONE.

Source files
------------

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - byte-stream program loader writing 32-bit words into instruction memory
module imem_program_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_write_en,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] word_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_idx;
  logic [31:0] word_idx;
  logic [31:0] assembled;
  logic [31:0] len_full;
  logic        take;

  // Length word as it will look once the final (4th) byte lands this cycle.
  assign len_full       = {byte_in, assembled[23:0]};
  assign take           = byte_valid && byte_ready;
  assign mem_addr       = BASE_ADDR + {30'd0, word_idx, 2'b00};
  assign mem_write_data = assembled;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    byte_ready   = 1'b0;
    mem_write_en = 1'b0;
    cpu_hold     = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LEN;
      end
      LEN: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_idx == 2'd3) begin
          if (len_full == 32'd0)                 state_next = DONE;
          else if (len_full > 32'(MAX_WORDS))    state_next = ERROR;
          else                                   state_next = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_idx == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        if (word_idx + 32'd1 == word_count) state_next = DONE;
        else                                state_next = DATA;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_next = LEN;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byte_idx   <= 2'd0;
      word_idx   <= 32'd0;
      assembled  <= 32'd0;
      word_count <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            byte_idx <= 2'd0;
            word_idx <= 32'd0;
          end
        end
        LEN, DATA: begin
          if (take) begin
            assembled[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx <= byte_idx + 2'd1;
            if (state == LEN && byte_idx == 2'd3) begin
              word_count <= len_full;
              word_idx   <= 32'd0;
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - directed self-checking bench for imem_program_loader
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        a_ready, a_we, a_hold, a_done, a_err;
  logic [63:0] a_addr;
  logic [31:0] a_wdata, a_wc;
  logic        b_ready, b_we, b_hold, b_done, b_err;
  logic [63:0] b_addr;
  logic [31:0] b_wdata, b_wc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_take = 0;
  int first_take = 0;
  int t1 = 0;

  logic [63:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_program_loader #(.BASE_ADDR(64'd0), .MAX_WORDS(256)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(a_ready), .mem_write_en(a_we),
    .mem_addr(a_addr), .mem_write_data(a_wdata), .cpu_hold(a_hold),
    .done(a_done), .error(a_err), .word_count(a_wc)
  );

  imem_program_loader #(.BASE_ADDR(64'h1000), .MAX_WORDS(256)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(b_ready), .mem_write_en(b_we),
    .mem_addr(b_addr), .mem_write_data(b_wdata), .cpu_hold(b_hold),
    .done(b_done), .error(b_err), .word_count(b_wc)
  );

  always @(negedge clk) begin
    if (a_we) begin
      wa_q.push_back(a_addr);
      wd_q.push_back(a_wdata);
      wc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic log_clear();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit got = 1'b0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      if (a_ready) begin
        last_take = cyc;
        step();
        got = 1'b1;
      end
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: byte_ready observed 0 expected 1");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    send_byte(w[7:0]);
    first_take = last_take;
    for (int k = 1; k < 4; k++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(w[8*k +: 8]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_ready", a_ready, 0);
    check("rst_we", a_we, 0);
    check("rst_addr", a_addr, 64'h0);
    check("rst_addr_b", b_addr, 64'h1000);
    check("rst_wdata", a_wdata, 0);
    check("rst_hold", a_hold, 1);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    check("rst_wc", a_wc, 0);
    step();
    reset_n = 1'b1;

    // two-word program, byte_valid held high
    log_clear();
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h00A00513, 0);
    send_word(32'h00B50463, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    check("t1_we", a_we, 1);
    check("t1_addr", a_addr, 64'h4);
    check("t1_addr_b", b_addr, 64'h1004);
    check("t1_wdata", a_wdata, 32'h00B50463);
    check("t1_hold_write", a_hold, 1);
    check("t1_ready_write", a_ready, 0);
    step();
    @(negedge clk);
    check("t1_done", a_done, 1);
    check("t1_hold", a_hold, 0);
    check("t1_we_after", a_we, 0);
    check("t1_wc", a_wc, 2);
    check("t1_nwrites", wa_q.size(), 2);
    if (wa_q.size() >= 2) begin
      check("t1_w0_addr", wa_q[0], 64'h0);
      check("t1_w0_data", wd_q[0], 32'h00A00513);
      check("t1_w1_addr", wa_q[1], 64'h4);
      check("t1_w1_data", wd_q[1], 32'h00B50463);
      check("t1_spacing", wc_q[1] - wc_q[0], 5);
    end

    // N=0
    step();
    log_clear();
    pulse_start();
    send_word(32'd0, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    check("t2_done", a_done, 1);
    check("t2_hold", a_hold, 0);
    check("t2_wc", a_wc, 0);
    step();
    idle(3);
    check("t2_nwrites", wa_q.size(), 0);

    // N=257 -> error, sticky through start
    pulse_start();
    send_word(32'd257, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    check("t3_err", a_err, 1);
    check("t3_hold", a_hold, 1);
    check("t3_ready", a_ready, 0);
    check("t3_done", a_done, 0);
    check("t3_wc", a_wc, 32'd257);
    step();
    pulse_start();
    byte_in = 8'h00;
    byte_valid = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("t3_err_sticky", a_err, 1);
    check("t3_ready_sticky", a_ready, 0);
    check("t3_we_sticky", a_we, 0);
    step();
    byte_valid = 1'b0;
    reset_n = 1'b0;
    step();
    @(negedge clk);
    check("t3_err_cleared", a_err, 0);
    check("t3_hold_rst", a_hold, 1);
    check("t3_wc_rst", a_wc, 0);
    step();
    reset_n = 1'b1;

    // N=MAX_WORDS is accepted
    pulse_start();
    send_word(32'd256, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    check("bnd_ready", a_ready, 1);
    check("bnd_err", a_err, 0);
    check("bnd_wc", a_wc, 32'd256);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;

    // three words with random gaps; first byte of each word offered during WRITE
    log_clear();
    pulse_start();
    send_word(32'd3, 2);
    send_word(32'h11223344, 3);
    send_word(32'hA5A55A5A, 3);
    t1 = first_take;
    send_word(32'h00000001, 3);
    byte_valid = 1'b0;
    @(negedge clk);
    check("t4_we", a_we, 1);
    check("t4_addr", a_addr, 64'h8);
    step();
    @(negedge clk);
    check("t4_done", a_done, 1);
    check("t4_nwrites", wa_q.size(), 3);
    if (wa_q.size() >= 3) begin
      check("t4_w0_data", wd_q[0], 32'h11223344);
      check("t4_w1_addr", wa_q[1], 64'h4);
      check("t4_w1_data", wd_q[1], 32'hA5A55A5A);
      check("t4_w2_data", wd_q[2], 32'h00000001);
      check("t4_held_byte", t1, wc_q[0] + 1);
    end

    // reload from DONE
    step();
    log_clear();
    pulse_start();
    @(negedge clk);
    check("t6_done_clr", a_done, 0);
    check("t6_hold_set", a_hold, 1);
    step();
    send_word(32'd1, 0);
    send_word(32'hDEADBEEF, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    check("t6_we", a_we, 1);
    check("t6_addr", a_addr, 64'h0);
    check("t6_wdata", a_wdata, 32'hDEADBEEF);
    check("t6_hold_write", a_hold, 1);
    step();
    @(negedge clk);
    check("t6_done", a_done, 1);
    check("t6_hold", a_hold, 0);

    // reset mid-load, then fresh load at BASE_ADDR 0x1000
    step();
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'hAABBCCDD, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    byte_valid = 1'b0;
    reset_n = 1'b0;
    step();
    @(negedge clk);
    check("t5_ready", b_ready, 0);
    check("t5_we", b_we, 0);
    check("t5_addr", b_addr, 64'h1000);
    check("t5_wdata", b_wdata, 0);
    check("t5_hold", b_hold, 1);
    check("t5_done", b_done, 0);
    check("t5_err", b_err, 0);
    check("t5_wc", b_wc, 0);
    step();
    reset_n = 1'b1;
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    check("t5_new_we", b_we, 1);
    check("t5_new_addr", b_addr, 64'h1000);
    check("t5_new_wdata", b_wdata, 32'hCAFEF00D);
    step();
    @(negedge clk);
    check("t5_new_done", b_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
